// File: rtl/motor_drive_ctrl.sv
// Two-wheel line-following motor drive: synchronised sensor inputs, ramped PWM duties,
// and an obstacle handler that actively brakes, then waits for a sustained clear path.
module motor_drive_ctrl #(
    parameter int PWM_W        = 8,
    parameter int SENSE_W      = 3,
    parameter int DEADBAND     = 1,
    parameter int FULL_DUTY    = 255,
    parameter int TURN_DUTY    = 96,
    parameter int RAMP_DIV     = 1000,
    parameter int RAMP_STEP    = 8,
    parameter int BRAKE_CYCLES = 50000,
    parameter int CLEAR_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [SENSE_W-1:0] induct,
    input  logic               proxim,
    output logic [3:0]         motor_in,
    output logic [1:0]         motor_en,
    output logic [1:0]         state,
    output logic [PWM_W-1:0]   duty_a,
    output logic [PWM_W-1:0]   duty_b
);

    localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int BRK_W = (BRAKE_CYCLES > 1) ? $clog2(BRAKE_CYCLES) : 1;
    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam int CENTRE = 2 ** (SENSE_W - 1);

    localparam logic [SENSE_W:0]   LO_TH     = (SENSE_W + 1)'(CENTRE - DEADBAND);
    localparam logic [SENSE_W:0]   HI_TH     = (SENSE_W + 1)'(CENTRE + DEADBAND);
    localparam logic [PWM_W-1:0]   FULL_D    = PWM_W'(FULL_DUTY);
    localparam logic [PWM_W-1:0]   TURN_D    = PWM_W'(TURN_DUTY);
    localparam logic [PWM_W:0]     STEP_X    = (PWM_W + 1)'(RAMP_STEP);
    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(RAMP_DIV - 1);
    localparam logic [BRK_W-1:0]   BRK_LOAD  = BRK_W'(BRAKE_CYCLES - 1);
    localparam logic [CLR_W-1:0]   CLR_LAST  = CLR_W'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BRAKE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_en_s1, r_en_s2;
    logic               r_px_s1, r_px_s2;
    logic [SENSE_W-1:0] r_ind_s1, r_ind_s2;
    logic [PWM_W-1:0]   r_pwm_cnt;
    logic [PRE_W-1:0]   r_pre;
    logic [BRK_W-1:0]   r_brk;
    logic [CLR_W-1:0]   r_clr;
    logic [PWM_W-1:0]   r_duty_a, r_duty_b;
    logic [PWM_W-1:0]   w_tgt_a, w_tgt_b;

    // One ramp step at PWM_W+1 bits so the carry/borrow shows up as saturation.
    function automatic logic [PWM_W-1:0] f_ramp(input logic [PWM_W-1:0] cur,
                                                input logic [PWM_W-1:0] tgt);
        logic [PWM_W:0] up;
        logic [PWM_W:0] dn;
        up = {1'b0, cur} + STEP_X;
        dn = {1'b0, cur} - STEP_X;
        if (cur < tgt)
            f_ramp = (up > {1'b0, tgt}) ? tgt : up[PWM_W-1:0];
        else if (cur > tgt)
            f_ramp = (dn[PWM_W] || dn < {1'b0, tgt}) ? tgt : dn[PWM_W-1:0];
        else
            f_ramp = cur;
    endfunction

    always_comb begin
        w_tgt_a = FULL_D;
        w_tgt_b = FULL_D;
        if ({1'b0, r_ind_s2} < LO_TH)
            w_tgt_a = TURN_D;
        else if ({1'b0, r_ind_s2} > HI_TH)
            w_tgt_b = TURN_D;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_en_s1   <= 1'b0;
            r_en_s2   <= 1'b0;
            r_px_s1   <= 1'b0;
            r_px_s2   <= 1'b0;
            r_ind_s1  <= '0;
            r_ind_s2  <= '0;
            r_pwm_cnt <= '0;
            r_pre     <= '0;
            r_brk     <= '0;
            r_clr     <= '0;
            r_duty_a  <= '0;
            r_duty_b  <= '0;
        end else begin
            r_en_s1   <= enable;
            r_en_s2   <= r_en_s1;
            r_px_s1   <= proxim;
            r_px_s2   <= r_px_s1;
            r_ind_s1  <= induct;
            r_ind_s2  <= r_ind_s1;
            r_pwm_cnt <= r_pwm_cnt + 1'b1;

            case (r_state)
                IDLE: begin
                    r_duty_a <= '0;
                    r_duty_b <= '0;
                    if (!r_px_s2 && r_en_s2) begin
                        r_state <= RUN;
                        r_pre   <= '0;
                    end
                end
                RUN: begin
                    if (r_px_s2) begin
                        r_state  <= BRAKE;
                        r_brk    <= BRK_LOAD;
                        r_duty_a <= '0;
                        r_duty_b <= '0;
                    end else if (!r_en_s2) begin
                        r_state  <= IDLE;
                        r_duty_a <= '0;
                        r_duty_b <= '0;
                    end else if (r_pre == PRE_LAST) begin
                        r_pre    <= '0;
                        r_duty_a <= f_ramp(r_duty_a, w_tgt_a);
                        r_duty_b <= f_ramp(r_duty_b, w_tgt_b);
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                end
                BRAKE: begin
                    // Inputs are ignored until the full brake interval has elapsed.
                    if (r_brk == '0) begin
                        r_state <= r_en_s2 ? HOLD : IDLE;
                        r_clr   <= '0;
                    end else begin
                        r_brk <= r_brk - 1'b1;
                    end
                end
                HOLD: begin
                    if (r_px_s2) begin
                        r_clr <= '0;
                    end else if (!r_en_s2) begin
                        r_state <= IDLE;
                    end else if (r_clr == CLR_LAST) begin
                        r_state <= RUN;
                        r_pre   <= '0;
                        r_clr   <= '0;
                    end else begin
                        r_clr <= r_clr + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        motor_in = 4'b0000;
        motor_en = 2'b00;
        case (r_state)
            RUN: begin
                motor_in = 4'b0101;
                motor_en = {r_pwm_cnt < r_duty_a, r_pwm_cnt < r_duty_b};
            end
            BRAKE: begin
                motor_in = 4'b1111;
                motor_en = 2'b11;
            end
            default: begin
                motor_in = 4'b0000;
                motor_en = 2'b00;
            end
        endcase
    end

    assign state  = r_state;
    assign duty_a = r_duty_a;
    assign duty_b = r_duty_b;

endmodule

// File: doc/motor_drive_ctrl.md
MOTOR_DRIVE_CTRL -- requirements
Module: motor_drive_ctrl

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- PWM_W, 8: duty and PWM counter width.
- SENSE_W, 3: inductive line-sensor input width.
- DEADBAND, 1: half-width of the straight-ahead window around centre.
- FULL_DUTY, 255: cruise duty.
- TURN_DUTY, 96: inner-wheel duty when turning.
- RAMP_DIV, 1000: clocks per ramp tick.
- RAMP_STEP, 8: duty change per ramp tick.
- BRAKE_CYCLES, 50000: active-brake duration.
- CLEAR_CYCLES, 100000: continuous obstacle-free clocks needed to resume.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst, in, 1: asynchronous, active-high reset.
- enable, in, 1: run request.
- induct, in, SENSE_W: line-position sensor code.
- proxim, in, 1: obstacle detected, active-high.
- motor_in, out, 4: {IN4, IN3, IN2, IN1} bridge direction pins.
- motor_en, out, 2: {ENA, ENB} PWM enables.
- state, out, 2: FSM state code.
- duty_a, out, PWM_W: motor A applied duty.
- duty_b, out, PWM_W: motor B applied duty.

Function
REQ-003 enable, induct and proxim SHALL pass through 2-flop synchronisers; all decisions use the synchronised values, giving 2 clocks of input latency.
REQ-004 FSM states SHALL be encoded IDLE=0, RUN=1, BRAKE=2, HOLD=3.
REQ-005 IDLE: motor_in=0000, motor_en=00 (coast), duty_a=duty_b=0; enable high -> RUN, unless proxim is high, in which case remain IDLE.
REQ-006 RUN: motor_in=0101 (IN1=1, IN2=0, IN3=1, IN4=0, both forward); motor_en[1]=(pwm_cnt<duty_a), motor_en[0]=(pwm_cnt<duty_b).
REQ-007 pwm_cnt SHALL be a free-running PWM_W-bit counter that wraps 2^PWM_W-1 -> 0; duty 0 gives enable constantly low, and duty 2^PWM_W-1 gives enable low for exactly 1 clock per period.
REQ-008 Target duty decode, with C=2^(SENSE_W-1):
- induct < C-DEADBAND: target_a=TURN_DUTY, target_b=FULL_DUTY.
- induct > C+DEADBAND: target_a=FULL_DUTY, target_b=TURN_DUTY.
- Otherwise: both targets = FULL_DUTY.
REQ-009 Ramp prescaler SHALL count 0..RAMP_DIV-1 and pulse on wrap, only while in RUN; it is cleared on entry to RUN.
REQ-010 On each ramp pulse, each duty SHALL step RAMP_STEP toward its target, clamped to exactly the target with no overshoot and no wrap; a duty already equal to its target is unchanged.
REQ-011 Ramp arithmetic SHALL be performed at PWM_W+1 bits so that up-steps near 2^PWM_W-1 and down-steps near 0 saturate instead of wrapping.
REQ-012 RUN to BRAKE: proxim high SHALL move to BRAKE on the next clock, duty_a=duty_b=0 immediately, and load the brake counter with BRAKE_CYCLES-1.
REQ-013 RUN to IDLE: enable low (with proxim low) SHALL move to IDLE on the next clock.
REQ-014 BRAKE: motor_in=1111 and motor_en=11 (fast stop); the counter decrements once per clock; at 0, go to HOLD if enable is high, otherwise IDLE.
REQ-015 BRAKE SHALL NOT be exited early by enable or proxim changes.
REQ-016 HOLD: motor_in=0000, motor_en=00, duties 0; the clear counter increments while proxim is low and resets to 0 on any proxim high.
REQ-017 HOLD exits: clear counter reaching CLEAR_CYCLES-1 -> RUN, with the ramp restarting from duty 0; enable low -> IDLE.
REQ-018 Priority SHALL be rst > proxim > enable in every state.

Reset
REQ-019 rst high SHALL asynchronously force state=IDLE, motor_in=0000, motor_en=00, duty_a=duty_b=0, and clear pwm_cnt, the prescaler, the brake and clear counters, and all synchroniser flops.
REQ-020 Reset deassertion SHALL take effect on the next clk edge, with no glitch on motor_en.
REQ-021 rst mid-BRAKE or mid-ramp SHALL abandon the operation in progress; after release the block starts from IDLE.

Verification (PWM_W=4, RAMP_DIV=4, RAMP_STEP=4, FULL_DUTY=15, TURN_DUTY=6, BRAKE_CYCLES=5, CLEAR_CYCLES=8, SENSE_W=3, DEADBAND=1)
REQ-022 enable=1, induct=4, proxim=0 from reset -> RUN 3 clocks after enable; duties step 0,4,8,12,15 every 4 clocks, then hold at 15; motor_in=0101.
REQ-023 At steady 15/15, set induct=1 -> duty_a steps 11,7,6, then holds; duty_b stays 15; ENA is high 6 of every 16 clocks.
REQ-024 proxim pulse high for 1 clock in RUN -> BRAKE with motor_in=1111 and motor_en=11 for exactly 5 clocks, then HOLD; RUN resumes after 8 obstacle-free clocks with duties ramping from 0.
REQ-025 In HOLD, proxim re-asserts at clear count 6 -> counter restarts; RUN is entered only after 8 consecutive clear clocks.
REQ-026 enable drops during BRAKE -> BRAKE still lasts 5 clocks, then IDLE with motor_in=0000 and motor_en=00.
REQ-027 rst asserted mid-ramp at duty 8 -> outputs zero asynchronously within the same cycle; IDLE after release.
